// File: rtl/sqrt_pkg.sv
// Shared types and constants for the odd-subtraction square-root controller
// and the add/sub/max arithmetic unit it drives.
package sqrt_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RAD_W  = 7;
    localparam int unsigned ROOT_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] AU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] AU_SUB = 2'b10;
    localparam logic [SEL_W-1:0] AU_MAX = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sqrt_seq_ctrl.sv
// Integer square root of a 7-bit radicand by repeated odd-number subtraction,
// using an external pipelined AU for the subtract and its sign bit as borrow.
module sqrt_seq_ctrl
    import sqrt_pkg::*;
#(
    parameter int unsigned AU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [RAD_W-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [ROOT_W-1:0]    root,
    output logic [DATA_W-1:0]    remainder,
    output logic [DATA_W-1:0]    au_a,
    output logic [DATA_W-1:0]    au_b,
    output logic [SEL_W-1:0]     au_sel,
    input  logic [DATA_W-1:0]    au_out
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_odd;
    logic [ROOT_W-1:0]   r_root;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;

    // Operands and results come straight from the working registers.
    assign au_a      = r_rem;
    assign au_b      = r_odd;
    assign au_sel    = AU_SUB;
    assign root      = r_root;
    assign remainder = r_rem;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_odd   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem   <= {1'b0, radicand};
                        r_odd   <= DATA_W'(1);
                        r_root  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= CNT_W'(AU_LAT - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Sign bit of the difference is an exact borrow: operands never exceed 127.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!au_out[DATA_W-1]) begin
                        r_rem   <= au_out;
                        r_root  <= r_root + ROOT_W'(1);
                        r_odd   <= r_odd + DATA_W'(2);
                        r_state <= ISSUE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl: two instances (AU latency 1 and 3) each paired
// with a behavioural AU; results checked against a queue of expected values.
module tb_sqrt_seq_ctrl;
    import sqrt_pkg::*;

    typedef struct {
        logic [3:0] root;
        logic [7:0] rem;
        int         dcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [6:0] rad1 = '0, rad3 = '0;

    logic       busy1, done1, busy3, done3;
    logic [3:0] root1, root3;
    logic [7:0] rem1, rem3, a1, b1, a3, b3, out1, out3;
    logic [1:0] sel1, sel3;
    logic [7:0] s1_q, s2_q;

    exp_t       sb[$];
    logic [7:0] au_b_log[$];
    logic [31:0] busy_mask;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sqrt_seq_ctrl #(.AU_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .radicand(rad1),
        .busy(busy1), .done(done1), .root(root1), .remainder(rem1),
        .au_a(a1), .au_b(b1), .au_sel(sel1), .au_out(out1)
    );

    sqrt_seq_ctrl #(.AU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .radicand(rad3),
        .busy(busy3), .done(done3), .root(root3), .remainder(rem3),
        .au_a(a3), .au_b(b3), .au_sel(sel3), .au_out(out3)
    );

    function automatic logic [7:0] au_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        case (s)
            2'b10:   return a - b;
            2'b11:   return (a > b) ? a : b;
            default: return a + b;
        endcase
    endfunction

    // Behavioural AUs: registered result after 1 and 3 cycles.
    always_ff @(posedge clk) begin
        out1 <= au_f(a1, b1, sel1);
        s1_q <= au_f(a3, b3, sel3);
        s2_q <= s1_q;
        out3 <= s2_q;
    end

    function automatic exp_t model(input logic [6:0] rad, input int lat);
        exp_t e;
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(rad)) r++;
        e.root = 4'(r);
        e.rem  = 8'(int'(rad) - r * r);
        e.dcyc = (lat + 1) * (r + 1) + 1;
        return e;
    endfunction

    // Starts one computation and watches it; n counts cycles after the start cycle.
    task automatic run_op(input bit use3, input logic [6:0] rad, input int p1, input int p2,
                          input int rst_at, output int dcyc, output logic [3:0] r_o,
                          output logic [7:0] rm_o);
        logic bsy, dn;
        logic [7:0] bb;
        au_b_log.delete();
        busy_mask = '0;
        dcyc = -1;
        r_o = 'x;
        rm_o = 'x;
        @(negedge clk);
        if (use3) begin start3 = 1'b1; rad3 = rad; end
        else      begin start1 = 1'b1; rad1 = rad; end
        @(negedge clk);
        for (int n = 1; n <= 200; n++) begin
            if (use3) begin
                start3 = (n == p1 || n == p2);
                rad3 = 7'($urandom_range(127));
                bsy = busy3; dn = done3; bb = b3;
            end else begin
                start1 = (n == p1 || n == p2);
                rad1 = 7'($urandom_range(127));
                bsy = busy1; dn = done1; bb = b1;
            end
            if (n == rst_at) begin
                start1 = 1'b0;
                start3 = 1'b0;
                rst_n = 1'b0;
                #1;
                dcyc = -2;
                break;
            end
            if (n < 32) busy_mask[n] = bsy;
            if (bsy && (au_b_log.size() == 0 || au_b_log[$] != bb)) au_b_log.push_back(bb);
            if (dn) begin
                dcyc = n;
                r_o  = use3 ? root3 : root1;
                rm_o = use3 ? rem3 : rem1;
                break;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy1, done1, busy3, done3} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy1, done1, busy3, done3}); else n_pass++;
        n_checks++;
        if ({root1, rem1, a1, b1} !== 28'h0) $display("FAIL reset_data1 got %h want 0", {root1, rem1, a1, b1}); else n_pass++;
        n_checks++;
        if ({root3, rem3, a3, b3} !== 28'h0) $display("FAIL reset_data3 got %h want 0", {root3, rem3, a3, b3}); else n_pass++;
        n_checks++;
        if ({sel1, sel3} !== 4'b1010) $display("FAIL reset_sel got %b want 1010", {sel1, sel3}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_result(input string nm, input int dcyc, input logic [3:0] r, input logic [7:0] rm);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (dcyc !== e.dcyc) $display("FAIL %s done_cycle got %0d want %0d", nm, dcyc, e.dcyc); else n_pass++;
        n_checks++;
        if (r !== e.root) $display("FAIL %s root got %0d want %0d", nm, r, e.root); else n_pass++;
        n_checks++;
        if (rm !== e.rem) $display("FAIL %s remainder got %0d want %0d", nm, rm, e.rem); else n_pass++;
    endtask

    task automatic test_zero();
        int d; logic [3:0] r; logic [7:0] rm;
        sb.push_back(model(7'd0, 1));
        run_op(1'b0, 7'd0, -1, -1, -1, d, r, rm);
        check_result("rad0", d, r, rm);
        n_checks++;
        if (busy_mask !== 32'h6) $display("FAIL rad0 busy_cycles got %h want 00000006", busy_mask); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done1 !== 1'b0) $display("FAIL rad0 done_pulse got %b want 0", done1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d; logic [3:0] r; logic [7:0] rm;
        sb.push_back(model(7'd16, 1));
        run_op(1'b0, 7'd16, -1, -1, -1, d, r, rm);
        check_result("rad16", d, r, rm);
        sb.push_back(model(7'd127, 1));
        run_op(1'b0, 7'd127, -1, -1, -1, d, r, rm);
        check_result("rad127", d, r, rm);
        n_checks++;
        if (au_b_log.size() != 12) $display("FAIL rad127 au_b_steps got %0d want 12", au_b_log.size()); else n_pass++;
        for (int i = 0; i < au_b_log.size() && i < 12; i++) begin
            n_checks++;
            if (au_b_log[i] !== 8'(2 * i + 1)) $display("FAIL rad127 au_b[%0d] got %0d want %0d", i, au_b_log[i], 2 * i + 1); else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy1, done1, root1, rem1} !== {2'b00, 4'd11, 8'd6}) $display("FAIL idle_hold got %h want %h", {busy1, done1, root1, rem1}, {2'b00, 4'd11, 8'd6}); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int d; logic [3:0] r; logic [7:0] rm;
        sb.push_back(model(7'd100, 1));
        run_op(1'b0, 7'd100, 5, 21, -1, d, r, rm);
        check_result("rad100_pulses", d, r, rm);
    endtask

    task automatic test_mid_reset();
        int d; logic [3:0] r; logic [7:0] rm;
        run_op(1'b0, 7'd50, -1, -1, 6, d, r, rm);
        n_checks++;
        if (d !== -2) $display("FAIL midreset reached got %0d want -2", d); else n_pass++;
        n_checks++;
        if ({busy1, done1, root1, rem1, a1, b1} !== 30'h0) $display("FAIL midreset outputs got %h want 0", {busy1, done1, root1, rem1, a1, b1}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL midreset idle_busy got %b want 0", busy1); else n_pass++;
        sb.push_back(model(7'd9, 1));
        run_op(1'b0, 7'd9, -1, -1, -1, d, r, rm);
        check_result("rad9_after_reset", d, r, rm);
    endtask

    task automatic test_lat3();
        int d; logic [3:0] r; logic [7:0] rm;
        sb.push_back(model(7'd10, 3));
        run_op(1'b1, 7'd10, -1, -1, -1, d, r, rm);
        check_result("lat3_rad10", d, r, rm);
        sb.push_back(model(7'd127, 3));
        run_op(1'b1, 7'd127, -1, -1, -1, d, r, rm);
        check_result("lat3_rad127", d, r, rm);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_zero();
        test_back_to_back();
        test_start_ignored();
        test_mid_reset();
        test_lat3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Sequencing controller that computes the integer square root of a 7-bit unsigned radicand by repeated odd-number subtraction. It sits directly upstream of the 2-stage add/sub/max arithmetic unit, drives the unit's operands and select, and consumes the unit's registered result. It delivers root and remainder with a start/done handshake.

## Interface
- `AU_LAT`, default 1: cycles from operands presented at the AU to a valid `au_out`; legal range 1..3.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a computation; sampled only in IDLE.
- `radicand`, input, 7: unsigned operand; captured on the accepted `start` edge.
- `busy`, output, 1: high in ISSUE and WAIT.
- `done`, output, 1: single-cycle pulse in DONE.
- `root`, output, 4: floor(sqrt(radicand)); valid from DONE until the next accepted start.
- `remainder`, output, 8: radicand − root²; valid alongside `root`.
- `au_a`, output, 8: AU operand A, equal to the current remainder register.
- `au_b`, output, 8: AU operand B, equal to the current odd register.
- `au_sel`, output, 2: AU select, constant `2'b10` (subtract).
- `au_out`, input, 8: AU result, equal to `au_a`−`au_b` presented `AU_LAT` cycles earlier.

## Operation
- AU select encoding: `00` and `01` add, `10` sub (A−B), `11` max. This block uses sub only.
- Internal registers:
  - `rem_q`[7:0]
  - `odd_q`[7:0]
  - `root_q`[3:0]
  - wait counter [1:0]
- States:
  - IDLE:
    - `start`=1 → `rem_q`←{0,`radicand`}, `odd_q`←1, `root_q`←0, go to ISSUE.
    - `start`=0 → stay.
  - ISSUE: operands are on `au_a`/`au_b`; load wait counter with `AU_LAT`−1; go to WAIT.
  - WAIT:
    - Counter ≠0 → decrement and stay.
    - Counter =0 → examine `au_out`:
      - `au_out`[7]=0 (non-negative): `rem_q`←`au_out`, `root_q`←`root_q`+1, `odd_q`←`odd_q`+2, go to ISSUE.
      - `au_out`[7]=1: go to DONE, keeping `rem_q` and `root_q`.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Width rule: the radicand is limited to 7 bits, so every `rem_q` and `odd_q` value is ≤127. Bit 7 of the difference is therefore an exact borrow.
- Range limits: maximum root is 11 and maximum `odd_q` is 23, so no overflow is possible.
- `start` during ISSUE, WAIT or DONE is ignored, with no queuing.
- `root` and `remainder` are driven from `root_q` and `rem_q` and hold their values through IDLE.
- Reset values (asynchronous, `rst_n`=0):
  - state IDLE
  - `busy` 0, `done` 0
  - `root` 0, `remainder` 0
  - `rem_q` 0, `odd_q` 0
  - `au_a` 0, `au_b` 0
  - `au_sel` `2'b10`
- Reset asserted mid-computation aborts immediately. After release the block waits in IDLE for a new `start`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Each iteration takes `AU_LAT`+1 cycles: one ISSUE cycle plus `AU_LAT` WAIT cycles.
- A result with root r needs r+1 iterations; the last one is the failing subtract.
- `done` is high in cycle (`AU_LAT`+1)(r+1)+1. With `AU_LAT`=1 this is cycle 2r+3.
- `au_out` is sampled only on the final WAIT cycle of an iteration. It is ignored in all other cycles.
- The earliest next accepted `start` is the cycle after DONE.
- `au_a`/`au_b` are stable from ISSUE through WAIT of each iteration. They change only on the WAIT→ISSUE edge.

## Structure
- Shared package `sqrt_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE)
  - AU select constants `AU_ADD`=2'b00, `AU_SUB`=2'b10, `AU_MAX`=2'b11
  - `DATA_W`=8
- Single module with no sub-modules. The wait counter is inline.
- The bench pairs this block with the real 2-stage AU, or a behavioural model with 1-cycle registered latency. `au_*` are wired directly.

## Test plan
- radicand 0, `AU_LAT`=1 → `done` in cycle 3, root 0, remainder 0; `busy` high in cycles 1–2 only.
- radicand 16 → root 4, remainder 0, `done` in cycle 11.
- radicand 127 → root 11, remainder 6, `done` in cycle 25; `au_b` steps 1,3,…,23.
- radicand 100, then `start` pulsed in cycles 5 and 21 → both pulses ignored; root 10, remainder 0, `done` in cycle 23.
- radicand 50, `rst_n` low in cycle 6 → all outputs 0 and `busy` 0 immediately. After release, a new start with radicand 9 gives root 3, remainder 0, `done` in cycle 9.
- `AU_LAT`=3 with a 3-cycle AU model, radicand 10 → root 3, remainder 1, `done` in cycle 17.
